data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits; only 32 is supported.
REQ-002 Parameter DEPTH, default 1024, number of WIDTH-bit words; power of two.
REQ-003 Parameter SPLIT_EN, default 1; 1 = misaligned accesses are split, 0 = misaligned accesses are rejected with err_o.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_i  input  1  access request; accepted when req_i && ready_o.
REQ-007 we_i  input  1  1 = store, 0 = load.
REQ-008 memtype_i  input  2  00 = byte, 01 = half, 10 = word; 11 = reserved, treated as word.
REQ-009 memsign_i  input  1  1 = sign-extend, 0 = zero-extend the load result.
REQ-010 a_i  input  WIDTH  byte address.
REQ-011 wd_i  input  WIDTH  store data, right-aligned.
REQ-012 ready_o  output  1  controller can accept a request this cycle.
REQ-013 rvalid_o  output  1  one-cycle pulse; rd_o is valid.
REQ-014 rd_o  output  WIDTH  load result, extended to WIDTH.
REQ-015 err_o  output  1  one-cycle pulse; misaligned request rejected (SPLIT_EN=0 only).

Function
REQ-016 Word index SHALL be a_i[log2(DEPTH)+1:2] and byte offset a_i[1:0]; upper address bits are ignored.
REQ-017 Word index SHALL wrap modulo DEPTH: word DEPTH-1 plus 1 becomes word 0.
REQ-018 An access is misaligned when offset + size exceeds 4 bytes (half at offset 3; word at offset 1..3).
REQ-019 FSM states SHALL be IDLE and SPLIT; ready_o = 1 in IDLE and 0 in SPLIT.
REQ-020 Aligned accept in cycle N: store commits at edge N, with byte enables for the addressed lanes only.
REQ-021 Aligned accept in cycle N: load gives rvalid_o = 1 in cycle N+1; back-to-back accepts are allowed every cycle.
REQ-022 Misaligned accept in cycle N (SPLIT_EN=1): FSM goes IDLE->SPLIT.
REQ-023 On a misaligned access, the first word (lanes offset..3) is accessed at edge N and the second word (lanes 0..remaining) at edge N+1; FSM returns SPLIT->IDLE.
REQ-024 A misaligned load SHALL pulse rvalid_o in cycle N+2, with the bytes from both words merged in little-endian order.
REQ-025 A misaligned store SHALL write only the required lanes of both words; no other byte changes.
REQ-026 SPLIT_EN=0 with a misaligned request: the request is accepted, err_o pulses in cycle N+1, no write occurs and rvalid_o stays 0.
REQ-027 A load SHALL extend bit 7 (byte) or bit 15 (half) when memsign_i=1, and zero-fill otherwise; word loads are unmodified.
REQ-028 A load issued the cycle after a store to the same bytes SHALL return the new data.
REQ-029 Request inputs SHALL be registered at accept; changes on the inputs during SPLIT have no effect.
REQ-030 rd_o SHALL hold its last value when rvalid_o = 0.

Reset
REQ-031 Reset asserted SHALL force the FSM to IDLE with ready_o=1, rvalid_o=0, err_o=0 and rd_o=0.
REQ-032 Reset during SPLIT SHALL abort the access: the second-word write is suppressed and no rvalid_o pulse follows.
REQ-033 RAM contents SHALL NOT be reset.

Structure
REQ-034 Package mem_pkg SHALL hold the memtype encoding (MEM_BYTE, MEM_HALF, MEM_WORD), the FSM state enum and the lane-mask function.
REQ-035 Storage SHALL be one sub-module, ram_be: synchronous write with 4-bit byte enable and registered read port, DEPTH words.

Verification
REQ-036 Word store 0xDEADBEEF at 0x10, then signed byte load at 0x13 -> rvalid_o at N+1, rd_o=0xFFFFFFDE.
REQ-037 Word 0x11223344 at 0x20 and word 0x55667788 at 0x24, then word load at 0x22 -> rvalid_o at N+2, rd_o=0x77881122; ready_o=0 in N+1.
REQ-038 Half store 0xABCD at 0x27 over words of zero -> word 0x24 = 0xCD000000, word 0x28 = 0x000000AB.
REQ-039 DEPTH=16: word load at 0x3E -> bytes taken from word 15 and word 0 (wrap).
REQ-040 Misaligned store at 0x31, reset pulsed in SPLIT -> word 0x34 unchanged; no rvalid_o pulse.
REQ-041 SPLIT_EN=0, word load at 0x01 -> err_o pulse at N+1; rvalid_o stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memtype encoding, controller states and lane-mask helper
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    // Bits [3:0] are lanes of the addressed word, bits [7:4] spill into the next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] memtype, input logic [1:0] offset);
        logic [7:0] base;
        case (memtype)
            MEM_BYTE: base = 8'h01;
            MEM_HALF: base = 8'h03;
            default:  base = 8'h0F;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/ram_be.sv
// rtl/ram_be.sv - single-port word RAM with byte-enable write and registered read
module ram_be #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wd,
    output logic [31:0]   o_rd
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wd[8*b +: 8];
            end
        end
        r_rd <= r_mem[i_addr];
    end

    assign o_rd = r_rd;

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte/half/word data memory controller with misaligned split
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [1:0]       memtype_i,
    input  logic             memsign_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic             ready_o,
    output logic             rvalid_o,
    output logic [WIDTH-1:0] rd_o,
    output logic             err_o
);

    localparam int AW = $clog2(DEPTH);

    state_t             r_state, w_state_nxt;
    logic               w_accept, w_misal, w_reject;
    logic [7:0]         w_mask;
    logic [2*WIDTH-1:0] w_wd_shift, w_pair, w_shift;
    logic               r_we, r_sign, r_pair, r_rvalid, r_err;
    logic [1:0]         r_off, r_type;
    logic [AW-1:0]      r_widx, w_ram_addr;
    logic [3:0]         r_be_hi, w_ram_be;
    logic               w_ram_we;
    logic [WIDTH-1:0]   r_wd_hi, r_lo, r_rd, w_ram_wd, w_ram_rd, w_word, w_rd;
    logic               w_unused;

    assign ready_o    = (r_state == ST_IDLE);
    assign w_accept   = req_i && ready_o;
    assign w_mask     = lane_mask(memtype_i, a_i[1:0]);
    assign w_misal    = |w_mask[7:4];
    assign w_reject   = w_misal && !SPLIT_EN;
    assign w_wd_shift = {{WIDTH{1'b0}}, wd_i} << {a_i[1:0], 3'b000};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // IDLE drives the RAM straight from the request; SPLIT replays the registered second half.
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_be    = w_mask[3:0];
        w_ram_addr  = a_i[AW+1:2];
        w_ram_wd    = w_wd_shift[WIDTH-1:0];
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_ram_we = we_i && !w_reject;
                    if (w_misal && SPLIT_EN) w_state_nxt = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                w_state_nxt = ST_IDLE;
                w_ram_we    = r_we;
                w_ram_be    = r_be_hi;
                w_ram_addr  = r_widx + AW'(1);
                w_ram_wd    = r_wd_hi;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    ram_be #(.DEPTH(DEPTH)) u_ram (
        .i_clk  (clk_i),
        .i_we   (w_ram_we),
        .i_be   (w_ram_be),
        .i_addr (w_ram_addr),
        .i_wd   (w_ram_wd),
        .o_rd   (w_ram_rd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we     <= 1'b0;
            r_sign   <= 1'b0;
            r_pair   <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_off    <= 2'b00;
            r_type   <= MEM_WORD;
            r_widx   <= '0;
            r_be_hi  <= 4'h0;
            r_wd_hi  <= '0;
            r_lo     <= '0;
            r_rd     <= '0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (r_rvalid) r_rd <= w_rd;
            if (r_state == ST_IDLE && w_accept) begin
                r_we    <= we_i;
                r_sign  <= memsign_i;
                r_off   <= a_i[1:0];
                r_type  <= memtype_i;
                r_widx  <= a_i[AW+1:2];
                r_be_hi <= w_mask[7:4];
                r_wd_hi <= w_wd_shift[2*WIDTH-1:WIDTH];
                r_pair  <= 1'b0;
                if (w_reject)               r_err    <= 1'b1;
                else if (!we_i && !w_misal) r_rvalid <= 1'b1;
            end
            if (r_state == ST_SPLIT) begin
                r_lo     <= w_ram_rd;
                r_pair   <= 1'b1;
                r_rvalid <= !r_we;
            end
        end
    end

    // Little-endian merge: the first word supplies the low bytes starting at the offset.
    assign w_pair = r_pair ? {w_ram_rd, r_lo} : {{WIDTH{1'b0}}, w_ram_rd};
    assign w_shift = w_pair >> {r_off, 3'b000};
    assign w_word  = w_shift[WIDTH-1:0];

    always_comb begin
        w_rd = w_word;
        case (r_type)
            MEM_BYTE: w_rd = {{(WIDTH-8){r_sign & w_word[7]}}, w_word[7:0]};
            MEM_HALF: w_rd = {{(WIDTH-16){r_sign & w_word[15]}}, w_word[15:0]};
            default:  w_rd = w_word;
        endcase
    end

    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign rd_o     = r_rvalid ? w_rd : r_rd;

    assign w_unused = ^{a_i[WIDTH-1:AW+2], w_shift[2*WIDTH-1:WIDTH]};

endmodule
